plugboard_pairs: RTL and testbench

- Parametrised, clocked Enigma plugboard (Steckerbrett) that sits on both sides of the rotor/reflector stack, on the keyboard→rero path and the rero→gui path.
- Stores up to MAX_PAIRS letter pairs written through a valid/ack command interface.
- Swaps letters bidirectionally: A↔B means A→B and B→A. Letters without a plug pass through unchanged.
- Rejects illegal plugs, supports pair removal and clear-all, and gives a registered one-hot lookup with valid tracking.

---
 rtl/plugboard_pairs.sv | 173 +++++++++++++++++
 tb/tb_plugboard_pairs.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard_pairs.sv
// Enigma plugboard: stores up to MAX_PAIRS letter swaps and translates
// one-hot letters through them with a registered lookup.
module plugboard_pairs #(
  parameter int N_LETTERS = 26,
  parameter int MAX_PAIRS = 10,
  parameter int CW        = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [N_LETTERS-1:0] cmd_a,
  input  logic [N_LETTERS-1:0] cmd_b,
  output logic                 cmd_ack,
  output logic                 cmd_err,
  input  logic                 in_valid,
  input  logic [N_LETTERS-1:0] in,
  output logic                 out_valid,
  output logic [N_LETTERS-1:0] out,
  output logic [CW-1:0]        pair_count,
  output logic                 full
);

  typedef logic [N_LETTERS-1:0] letter_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_REM = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  letter_t              a_q, a_d;
  letter_t              b_q, b_d;
  logic [MAX_PAIRS-1:0] vld_q, vld_d;
  letter_t              x_q [MAX_PAIRS];
  letter_t              x_d [MAX_PAIRS];
  letter_t              y_q [MAX_PAIRS];
  letter_t              y_d [MAX_PAIRS];
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 err_q, err_d;
  letter_t              out_q, mapped;
  logic                 ov_q;
  letter_t              plugged;
  logic                 found;

  function automatic logic is_onehot(input letter_t v);
    return (v != '0) && ((v & (v - letter_t'(1))) == '0);
  endfunction

  always_comb begin
    plugged = '0;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      if (vld_q[i]) plugged = plugged | x_q[i] | y_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    vld_d   = vld_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    found   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        err_d   = 1'b0;
        unique case (op_q)
          OP_ADD: begin
            if (!is_onehot(a_q) || !is_onehot(b_q) ||
                a_q == b_q || |((a_q | b_q) & plugged) ||
                full_q) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < MAX_PAIRS; i++) begin
                if (!found && !vld_q[i]) begin
                  vld_d[i] = 1'b1;
                  x_d[i]   = a_q;
                  y_d[i]   = b_q;
                  found    = 1'b1;
                end
              end
              cnt_d = cnt_q + CW'(1);
            end
          end
          OP_REM: begin
            if (!is_onehot(a_q) || !(|(a_q & plugged))) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < MAX_PAIRS; i++) begin
                if (vld_q[i] && (x_q[i] == a_q || y_q[i] == a_q))
                  vld_d[i] = 1'b0;
              end
              cnt_d = cnt_q - CW'(1);
            end
          end
          OP_CLR: begin
            vld_d = '0;
            cnt_d = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    full_d = (cnt_d == CW'(MAX_PAIRS));
  end

  // Lookup uses the table before this edge's commit.
  always_comb begin
    mapped = in;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      if (vld_q[i]) begin
        if (in == x_q[i])      mapped = y_q[i];
        else if (in == y_q[i]) mapped = x_q[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
      out_q   <= mapped;
      ov_q    <= in_valid;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  assign cmd_ack    = (state_q == S_DONE);
  assign cmd_err    = cmd_ack & err_q;
  assign out        = out_q;
  assign out_valid  = ov_q;
  assign pair_count = cnt_q;
  assign full       = full_q;

endmodule

// File: tb/tb_plugboard_pairs.sv
// Self-checking bench for plugboard_pairs: directed scenarios plus
// random commands and lookups against a partner-array model.
module tb_plugboard_pairs;

  localparam int N  = 26;
  localparam int MP = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [N-1:0]  cmd_a = '0;
  logic [N-1:0]  cmd_b = '0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_l = '0;
  logic          cmd_ack, cmd_err, out_valid, full;
  logic [N-1:0]  out_l;
  logic [CW-1:0] pair_count;

  int checks = 0;
  int errors = 0;
  int partner [N];
  int mcount;

  always #10 clk = ~clk;

  plugboard_pairs #(.N_LETTERS(N), .MAX_PAIRS(MP), .CW(CW)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_ack   (cmd_ack),
    .cmd_err   (cmd_err),
    .in_valid  (in_valid),
    .in        (in_l),
    .out_valid (out_valid),
    .out       (out_l),
    .pair_count(pair_count),
    .full      (full)
  );

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) partner[i] = -1;
    mcount = 0;
  endfunction

  function automatic logic [N-1:0] model_map(input logic [N-1:0] v);
    if ($countones(v) != 1) return v;
    if (partner[idx(v)] < 0) return v;
    return oh(partner[idx(v)]);
  endfunction

  // Returns the expected error flag and applies the command to the model.
  function automatic logic model_cmd(input logic [1:0] op,
                                     input logic [N-1:0] a,
                                     input logic [N-1:0] b);
    int ia, ib;
    case (op)
      2'b00: begin
        if ($countones(a) != 1 || $countones(b) != 1) return 1'b1;
        ia = idx(a);
        ib = idx(b);
        if (ia == ib) return 1'b1;
        if (partner[ia] >= 0 || partner[ib] >= 0) return 1'b1;
        if (mcount == MP) return 1'b1;
        partner[ia] = ib;
        partner[ib] = ia;
        mcount++;
        return 1'b0;
      end
      2'b01: begin
        if ($countones(a) != 1) return 1'b1;
        ia = idx(a);
        if (partner[ia] < 0) return 1'b1;
        ib = partner[ia];
        partner[ib] = -1;
        partner[ia] = -1;
        mcount--;
        return 1'b0;
      end
      2'b10: begin
        model_clear();
        return 1'b0;
      end
      default: return 1'b1;
    endcase
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, output logic got,
                        output logic err, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    got = 1'b0;
    err = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (cmd_ack) begin
        got = 1'b1;
        err = cmd_err;
        lat = c;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [N-1:0] v, output logic [N-1:0] o,
                           output logic ov);
    @(negedge clk);
    in_l = v;
    in_valid = 1'b1;
    @(negedge clk);
    o = out_l;
    ov = out_valid;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] o;
    logic ov;
    reset = 1'b0;
    in_valid = 1'b1;
    in_l = oh(5);
    repeat (2) @(negedge clk);
    checks++;
    if (pair_count !== '0 || full !== 1'b0) begin
      errors++;
      $display("FAIL rst_count: got %0d/%0b required 0/0", pair_count, full);
    end
    checks++;
    if (cmd_ack !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack: got %0b/%0b required 0/0", cmd_ack, cmd_err);
    end
    checks++;
    if (out_valid !== 1'b0 || out_l !== '0) begin
      errors++;
      $display("FAIL rst_out: got %0b/%h required 0/0", out_valid, out_l);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    model_clear();
    do_lookup(oh(0), o, ov);
    checks++;
    if (o !== oh(0) || ov !== 1'b1 || pair_count !== '0) begin
      errors++;
      $display("FAIL rst_lookup: got %h/%0b/%0d required %h/1/0",
               o, ov, pair_count, oh(0));
    end
  endtask

  task automatic test_add_lookup();
    logic got, err, e;
    int lat;
    logic [N-1:0] o;
    logic ov;
    do_cmd(2'b00, oh(0), oh(1), got, err, lat);
    e = model_cmd(2'b00, oh(0), oh(1));
    checks++;
    if (got !== 1'b1 || lat != 2 || err !== e) begin
      errors++;
      $display("FAIL add_ab: ack %0b lat %0d err %0b required 1/2/%0b",
               got, lat, err, e);
    end
    checks++;
    if (pair_count !== CW'(mcount)) begin
      errors++;
      $display("FAIL add_ab_cnt: got %0d required %0d", pair_count, mcount);
    end
    for (int i = 0; i < 3; i++) begin
      do_lookup(oh(i), o, ov);
      checks++;
      if (o !== model_map(oh(i)) || ov !== 1'b1) begin
        errors++;
        $display("FAIL lookup_%0d: got %h/%0b required %h/1",
                 i, o, ov, model_map(oh(i)));
      end
    end
  endtask

  task automatic test_add_errors();
    logic [1:0]   ops [6];
    logic [N-1:0] as  [6];
    logic [N-1:0] bs  [6];
    logic got, err, e;
    int lat;
    ops = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01};
    as  = '{oh(0), oh(3), oh(0) | oh(3), oh(6), oh(25), oh(0) | oh(1)};
    bs  = '{oh(2), oh(3), oh(4), oh(7), '0, '0};
    for (int k = 0; k < 6; k++) begin
      do_cmd(ops[k], as[k], bs[k], got, err, lat);
      e = model_cmd(ops[k], as[k], bs[k]);
      checks++;
      if (got !== 1'b1 || err !== 1'b1 || err !== e) begin
        errors++;
        $display("FAIL bad_cmd_%0d: ack %0b err %0b required 1/1", k, got, err);
      end
      checks++;
      if (pair_count !== CW'(mcount)) begin
        errors++;
        $display("FAIL bad_cnt_%0d: got %0d required %0d",
                 k, pair_count, mcount);
      end
    end
  endtask

  task automatic test_fill_full();
    logic got, err, e;
    int lat;
    logic [N-1:0] o;
    logic ov;
    for (int i = 1; i < MP; i++) begin
      do_cmd(2'b00, oh(2 * i), oh(2 * i + 1), got, err, lat);
      e = model_cmd(2'b00, oh(2 * i), oh(2 * i + 1));
      checks++;
      if (got !== 1'b1 || err !== e || pair_count !== CW'(mcount)) begin
        errors++;
        $display("FAIL fill_%0d: ack %0b err %0b cnt %0d required 1/%0b/%0d",
                 i, got, err, pair_count, e, mcount);
      end
    end
    checks++;
    if (full !== 1'b1 || pair_count !== CW'(MP)) begin
      errors++;
      $display("FAIL full: got %0b/%0d required 1/%0d", full, pair_count, MP);
    end
    do_cmd(2'b00, oh(24), oh(25), got, err, lat);
    e = model_cmd(2'b00, oh(24), oh(25));
    checks++;
    if (err !== 1'b1 || err !== e || pair_count !== CW'(MP)) begin
      errors++;
      $display("FAIL add_when_full: err %0b cnt %0d required 1/%0d",
               err, pair_count, MP);
    end
    do_cmd(2'b01, oh(1), '0, got, err, lat);
    e = model_cmd(2'b01, oh(1), '0);
    checks++;
    if (got !== 1'b1 || err !== e || pair_count !== CW'(mcount) ||
        full !== 1'b0) begin
      errors++;
      $display("FAIL remove_b: err %0b cnt %0d full %0b required %0b/%0d/0",
               err, pair_count, full, e, mcount);
    end
    do_lookup(oh(0), o, ov);
    checks++;
    if (o !== oh(0) || o !== model_map(oh(0))) begin
      errors++;
      $display("FAIL lookup_a_after_rm: got %h required %h", o, oh(0));
    end
  endtask

  task automatic test_back_to_back();
    logic got, err, e, ack_err;
    int lat, ack_c;
    logic [N-1:0] exp_old, exp_new, o;
    logic [N-1:0] obs [1:4];
    logic ov;
    do_cmd(2'b10, '0, '0, got, err, lat);
    e = model_cmd(2'b10, '0, '0);
    checks++;
    if (got !== 1'b1 || err !== e || pair_count !== '0) begin
      errors++;
      $display("FAIL clear1: err %0b cnt %0d required 0/0", err, pair_count);
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_a = oh(1);
    cmd_b = oh(4);
    in_l = oh(1);
    in_valid = 1'b1;
    exp_old = model_map(oh(1));
    e = model_cmd(2'b00, oh(1), oh(4));
    exp_new = model_map(oh(1));
    ack_c = 0;
    ack_err = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      obs[c] = out_l;
      if (cmd_ack && ack_c == 0) begin
        ack_c = c;
        ack_err = cmd_err;
        cmd_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ack_c != 2 || ack_err !== e) begin
      errors++;
      $display("FAIL stream_ack: cycle %0d err %0b required 2/%0b",
               ack_c, ack_err, e);
    end
    checks++;
    if (obs[2] !== exp_old) begin
      errors++;
      $display("FAIL stream_exec_edge: got %h required %h", obs[2], exp_old);
    end
    checks++;
    if (obs[3] !== exp_new || obs[4] !== exp_new) begin
      errors++;
      $display("FAIL stream_after: got %h/%h required %h",
               obs[3], obs[4], exp_new);
    end
    do_cmd(2'b10, '0, '0, got, err, lat);
    e = model_cmd(2'b10, '0, '0);
    checks++;
    if (got !== 1'b1 || err !== 1'b0 || pair_count !== '0) begin
      errors++;
      $display("FAIL clear2: err %0b cnt %0d required 0/0", err, pair_count);
    end
    for (int k = 0; k < 4; k++) begin
      int l;
      l = (k == 0) ? 1 : int'($urandom_range(0, N - 1));
      do_lookup(oh(l), o, ov);
      checks++;
      if (o !== oh(l)) begin
        errors++;
        $display("FAIL cleared_lookup_%0d: got %h required %h", k, o, oh(l));
      end
    end
  endtask

  task automatic test_reset_midcmd();
    logic got, err, e, any_ack;
    int lat;
    logic [N-1:0] o;
    logic ov;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_a = oh(2);
    cmd_b = oh(3);
    in_l = oh(2);
    in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    in_valid = 1'b0;
    model_clear();
    checks++;
    if (cmd_ack !== 1'b0 || out_valid !== 1'b0 || pair_count !== '0) begin
      errors++;
      $display("FAIL midrst_state: ack %0b ov %0b cnt %0d required 0/0/0",
               cmd_ack, out_valid, pair_count);
    end
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_ack = any_ack | cmd_ack;
    end
    checks++;
    if (any_ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_noack: got %0b required 0", any_ack);
    end
    do_lookup(oh(2), o, ov);
    checks++;
    if (o !== oh(2)) begin
      errors++;
      $display("FAIL midrst_empty: got %h required %h", o, oh(2));
    end
    do_cmd(2'b00, oh(2), oh(3), got, err, lat);
    e = model_cmd(2'b00, oh(2), oh(3));
    checks++;
    if (got !== 1'b1 || lat != 2 || err !== e || pair_count !== CW'(mcount)) begin
      errors++;
      $display("FAIL midrst_next: ack %0b lat %0d err %0b cnt %0d required 1/2/%0b/%0d",
               got, lat, err, pair_count, e, mcount);
    end
  endtask

  task automatic test_random();
    logic got, err, e, ov;
    int lat, sel;
    logic [1:0] op;
    logic [N-1:0] a, b, v, o;
    for (int k = 0; k < 200; k++) begin
      sel = int'($urandom_range(0, 19));
      a = oh(int'($urandom_range(0, N - 1)));
      b = oh(int'($urandom_range(0, N - 1)));
      if (sel < 12)      op = 2'b00;
      else if (sel < 17) op = 2'b01;
      else if (sel == 17) op = 2'b10;
      else if (sel == 18) op = 2'b11;
      else begin
        op = 2'b00;
        a = a | oh(int'($urandom_range(0, N - 1)));
      end
      do_cmd(op, a, b, got, err, lat);
      e = model_cmd(op, a, b);
      checks++;
      if (got !== 1'b1 || lat != 2 || err !== e) begin
        errors++;
        $display("FAIL rnd_cmd_%0d: op %0d ack %0b lat %0d err %0b required 1/2/%0b",
                 k, op, got, lat, err, e);
      end
      checks++;
      if (pair_count !== CW'(mcount) || full !== (mcount == MP)) begin
        errors++;
        $display("FAIL rnd_cnt_%0d: cnt %0d full %0b required %0d/%0b",
                 k, pair_count, full, mcount, (mcount == MP));
      end
      if ($urandom_range(0, 9) == 0) v = N'($urandom());
      else v = oh(int'($urandom_range(0, N - 1)));
      do_lookup(v, o, ov);
      checks++;
      if (o !== model_map(v) || ov !== 1'b1) begin
        errors++;
        $display("FAIL rnd_lookup_%0d: in %h got %h required %h",
                 k, v, o, model_map(v));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_add_lookup();
    test_add_errors();
    test_fill_full();
    test_back_to_back();
    test_reset_midcmd();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
